// File: rtl/alu_issue_sequencer_pkg.sv
// ALU issue sequencer shared types.
// Opcodes, group and FSM state enums.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_LT   = 4'd2;
  localparam logic [3:0] OP_GT   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SAR  = 4'd6;
  localparam logic [3:0] OP_ROTL = 4'd7;
  localparam logic [3:0] OP_ROTR = 4'd8;

  typedef enum logic [1:0] {
    GRP_NONE,
    GRP_ARITH,
    GRP_LOGIC,
    GRP_SHIFT
  } grp_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_e;

  function automatic logic [2:0] grp_en(grp_e g);
    logic [2:0] en;
    en = 3'b000;
    case (g)
      GRP_ARITH: en = 3'b100;
      GRP_LOGIC: en = 3'b010;
      GRP_SHIFT: en = 3'b001;
      default:   en = 3'b000;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/alu_issue_sequencer_if.sv
// Request/response and ALU-side bundle.
// slave = sequencer, master = environment.
interface alu_issue_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       alu_en;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_result;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_err;

  modport slave (
    input  in_valid, in_op, in_a, in_b,
    input  alu_result, out_ready,
    output in_ready, alu_en, alu_op,
    output alu_a, alu_b,
    output out_valid, out_data, out_err
  );

  modport master (
    output in_valid, in_op, in_a, in_b,
    output alu_result, out_ready,
    input  in_ready, alu_en, alu_op,
    input  alu_a, alu_b,
    input  out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_issue_sequencer_op_decode.sv
// Opcode to ALU group decode.
// Purely combinational.
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [3:0] op,
  output grp_e       grp,
  output logic       legal
);

  // map opcode onto its execution group
  always_comb begin
    grp   = GRP_NONE;
    legal = 1'b1;
    unique case (1'b1)
      (op <= OP_GT): grp = GRP_ARITH;
      (op == OP_XOR): grp = GRP_LOGIC;
      (op >= OP_SLL && op <= OP_ROTR):
        grp = GRP_SHIFT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_issue_sequencer.sv
// ALU issue sequencer: captures a request,
// drives the ALU for its latency, holds result.
module alu_issue_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int SHIFT_LAT = 3
) (
  input logic clk,
  input logic rst,
  alu_issue_sequencer_if.slave io
);

  state_e           state;
  state_e           state_nxt;
  logic [3:0]       cnt;
  logic [3:0]       cnt_nxt;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_nxt;
  logic             err_q;
  logic             err_nxt;
  logic             accept;
  logic [3:0]       op_sel;
  logic [3:0]       lat_m1;
  grp_e             grp;
  logic             legal;

  // accept in IDLE, or in RESP while the
  // consumer takes the held response
  always_comb begin
    io.in_ready = !rst &&
      (state == IDLE ||
       (state == RESP && io.out_ready));
  end

  assign accept = io.in_valid && io.in_ready;

  // decode the opcode being captured, which
  // equals the held opcode when no accept
  assign op_sel = accept ? io.in_op : op_q;

  alu_op_decode u_dec (
    .op    (op_sel),
    .grp   (grp),
    .legal (legal)
  );

  assign lat_m1 = (grp == GRP_SHIFT) ?
    4'(SHIFT_LAT - 1) : 4'd0;

  // next state, countdown and response capture
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    data_nxt  = data_q;
    err_nxt   = err_q;
    unique case (state)
      IDLE, RESP: begin
        if (accept) begin
          if (legal) begin
            state_nxt = EXEC;
            cnt_nxt   = lat_m1;
          end else begin
            state_nxt = RESP;
            data_nxt  = '0;
            err_nxt   = 1'b1;
          end
        end else if (state == RESP &&
                     io.out_ready) begin
          state_nxt = IDLE;
        end
      end
      EXEC: begin
        if (cnt == 4'd0) begin
          state_nxt = RESP;
          data_nxt  = io.alu_result;
          err_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, counter, request and response regs
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      data_q <= data_nxt;
      err_q  <= err_nxt;
      if (accept) begin
        op_q <= io.in_op;
        a_q  <= io.in_a;
        b_q  <= io.in_b;
      end
    end
  end

  assign io.alu_en = (state == EXEC) ?
    grp_en(grp) : 3'b000;
  assign io.alu_op    = op_q;
  assign io.alu_a     = a_q;
  assign io.alu_b     = b_q;
  assign io.out_valid = (state == RESP);
  assign io.out_data  = data_q;
  assign io.out_err   = err_q;

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed and random-stream bench for
// alu_issue_sequencer with a behavioural ALU.
module tb_alu_issue_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors    = 0;
  int miscompares = 0;

  alu_issue_sequencer_if #(.WIDTH(32)) bus ();

  alu_issue_sequencer #(
    .WIDTH     (32),
    .SHIFT_LAT (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .io  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_ref(
    logic [3:0] op, logic [31:0] a, logic [31:0] b);
    logic [63:0] d;
    logic [4:0]  s;
    s = b[4:0];
    d = {a, a};
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return {31'd0, a < b};
      4'd3: return {31'd0, a > b};
      4'd4: return a ^ b;
      4'd5: return a << s;
      4'd6: return $signed(a) >>> s;
      4'd7: begin d = d << s; return d[63:32]; end
      4'd8: begin d = d >> s; return d[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  assign bus.alu_result =
    alu_ref(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic chk(string tag,
                     logic [31:0] obs,
                     logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic offer(logic [3:0] op,
                       logic [31:0] a,
                       logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  logic [31:0] q_data[$];
  logic        q_err[$];
  logic [31:0] ed;
  logic        ee;
  int          sent;
  int          rcvd;
  int          seen;

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // reset
    tick();
    tick();
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_alu_en", 32'(bus.alu_en), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_err", 32'(bus.out_err), 0);
    chk("rst_alu_a", bus.alu_a, 0);
    chk("rst_alu_op", 32'(bus.alu_op), 0);
    rst = 1'b0;

    // ADD 5+7
    tick();
    offer(4'd0, 32'd5, 32'd7);
    #1;
    chk("add_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_op = 4'hF;
    bus.in_a = 32'hDEAD;
    #1;
    chk("add_alu_en", 32'(bus.alu_en), 32'b100);
    chk("add_alu_a", bus.alu_a, 32'd5);
    chk("add_alu_b", bus.alu_b, 32'd7);
    chk("add_ov_early", 32'(bus.out_valid), 0);
    tick();
    #1;
    chk("add_out_valid", 32'(bus.out_valid), 1);
    chk("add_out_data", bus.out_data, 32'd12);
    chk("add_out_err", 32'(bus.out_err), 0);
    chk("add_en_off", 32'(bus.alu_en), 0);

    // stall in RESP for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      #1;
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_data", bus.out_data, 32'd12);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
    end

    // back-to-back retire + XOR accept
    tick();
    offer(4'd4, 32'hF0F0, 32'h0FF0);
    bus.out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    chk("xor_alu_en", 32'(bus.alu_en), 32'b010);
    chk("xor_ov", 32'(bus.out_valid), 0);
    tick();
    #1;
    chk("xor_data", bus.out_data, 32'hFF00);
    chk("xor_ov2", 32'(bus.out_valid), 1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    #1;
    chk("xor_idle", 32'(bus.out_valid), 0);
    chk("idle_in_ready", 32'(bus.in_ready), 1);

    // SLL 1<<4, three EXEC cycles
    offer(4'd5, 32'd1, 32'd4);
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = 32'h55;
    bus.in_b = 32'h66;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("sll_alu_en", 32'(bus.alu_en), 32'b001);
      chk("sll_alu_a", bus.alu_a, 32'd1);
      chk("sll_alu_b", bus.alu_b, 32'd4);
      chk("sll_alu_op", 32'(bus.alu_op), 32'd5);
      chk("sll_ov", 32'(bus.out_valid), 0);
      tick();
    end
    #1;
    chk("sll_valid", 32'(bus.out_valid), 1);
    chk("sll_data", bus.out_data, 32'd16);
    chk("sll_en_off", 32'(bus.alu_en), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // illegal opcode
    offer(4'hB, 32'd3, 32'd3);
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("ill_valid", 32'(bus.out_valid), 1);
    chk("ill_err", 32'(bus.out_err), 1);
    chk("ill_data", bus.out_data, 0);
    chk("ill_alu_en", 32'(bus.alu_en), 0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;

    // reset during 2nd EXEC cycle of ROTR
    offer(4'd8, 32'd1, 32'd1);
    tick();
    bus.in_valid = 1'b0;
    tick();
    #1;
    chk("rotr_alu_en", 32'(bus.alu_en), 32'b001);
    rst = 1'b1;
    #1;
    chk("rotr_rst_rdy", 32'(bus.in_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rotr_ov", 32'(bus.out_valid), 0);
    chk("rotr_en", 32'(bus.alu_en), 0);
    chk("rotr_alu_a", bus.alu_a, 0);
    chk("rotr_idle_rdy", 32'(bus.in_ready), 1);
    bus.out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      #1;
      if (bus.out_valid) seen++;
    end
    chk("rotr_no_resp", seen, 0);

    // random stream with stalls
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 20000 &&
         (sent < 200 || q_data.size() > 0);
         cyc++) begin
      tick();
      bus.in_valid = (sent < 200) &&
        ($urandom_range(0, 3) != 0);
      bus.in_op = 4'($urandom_range(0, 15));
      bus.in_a = $urandom;
      bus.in_b = $urandom;
      bus.out_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q_data.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          ed = q_data.pop_front();
          ee = q_err.pop_front();
          chk("rnd_data", bus.out_data, ed);
          chk("rnd_err", 32'(bus.out_err), 32'(ee));
          rcvd++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (bus.in_op > 4'd8) begin
          q_data.push_back(32'd0);
          q_err.push_back(1'b1);
        end else begin
          q_data.push_back(alu_ref(bus.in_op,
                                   bus.in_a,
                                   bus.in_b));
          q_err.push_back(1'b0);
        end
        sent++;
      end
    end
    bus.in_valid = 1'b0;
    chk("rnd_sent", sent, 200);
    chk("rnd_rcvd", rcvd, 200);
    chk("rnd_left", q_data.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
